mem_req_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage.
- Latches the execute-stage result bus and checks load/store address alignment (raises ALE).
- Issues the data-SRAM-like request (req/wr/size/wstrb/addr/wdata, addr_ok handshake) and passes results to the memory-response stage (ms).
- Provides forwarding/stall info to decode. A pending request is never retracted on flush; the stage tells ms to discard its response instead.

---
 rtl/mem_req_stage.sv | 139 +++++++++++++
 tb/tb_mem_req_stage.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_stage.sv
// rtl/mem_req_stage.sv - memory request stage: latches execute results, checks alignment, issues data requests
// Optional feature macro: RS_ALE_CHECK_EN (misaligned access raises ALE instead of forcing alignment).
module mem_req_stage #(
  parameter int IN_WD  = 238,
  parameter int OUT_WD = 83
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              es_to_rs_valid,
  input  logic [IN_WD-1:0]  es_to_rs_bus,
  output logic              rs_allowin,
  input  logic              ms_allowin,
  output logic              rs_to_ms_valid,
  output logic [OUT_WD-1:0] rs_to_ms_bus,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  output logic              rs_discard,
  output logic [39:0]       rs_to_ds_bus
);

  typedef enum logic [1:0] {IDLE, WAIT, SENT} state_t;

  state_t           state;
  logic             rs_valid;
  logic             cancel;
  logic [IN_WD-1:0] bus_r;

  logic [31:0] pc, result, rkd, addr;
  logic [4:0]  dest;
  logic [5:0]  ecode_in, rs_ecode;
  logic        gr_we, ld_w, ld_b, ld_h, ld_bu, ld_hu, ex_in, st_w, st_h, st_b, mem_we;
  logic        is_ld, mem_op, byte_op, half_op, word_op, ale, rs_ex;
  logic        accept, ready_go, out_go;
  logic        unused_bits;

  assign pc       = bus_r[31:0];
  assign result   = bus_r[63:32];
  assign dest     = bus_r[68:64];
  assign gr_we    = bus_r[69];
  assign ld_w     = bus_r[70];
  assign ld_b     = bus_r[71];
  assign ld_h     = bus_r[72];
  assign ld_bu    = bus_r[73];
  assign ld_hu    = bus_r[74];
  assign ex_in    = bus_r[125];
  assign ecode_in = bus_r[131:126];
  assign rkd      = bus_r[197:166];
  assign st_w     = bus_r[198];
  assign st_h     = bus_r[199];
  assign st_b     = bus_r[200];
  assign mem_we   = bus_r[201];

  assign unused_bits = &{1'b0, bus_r[124:75], bus_r[165:132], bus_r[IN_WD-1:202]};

  assign is_ld   = ld_w | ld_b | ld_h | ld_bu | ld_hu;
  assign mem_op  = mem_we | is_ld;
  assign byte_op = ld_b | ld_bu | st_b;
  assign half_op = ld_h | ld_hu | st_h;
  assign word_op = ld_w | st_w;

`ifdef RS_ALE_CHECK_EN
  assign ale  = rs_valid & ~ex_in & ((word_op & (result[1:0] != 2'b00)) | (half_op & result[0]));
  assign addr = result;
`else
  // Without the check, misaligned addresses are silently rounded down to the access size.
  assign ale  = 1'b0;
  assign addr = word_op ? {result[31:2], 2'b00} :
                half_op ? {result[31:1], 1'b0}  : result;
`endif

  assign rs_ex    = ex_in | ale;
  assign rs_ecode = ale ? 6'h09 : ecode_in;

  assign data_req = (state == WAIT) |
                    ((state == IDLE) & rs_valid & mem_op & ~rs_ex & ~flush);
  assign accept   = data_req & data_addr_ok;
  assign ready_go = ~mem_op | rs_ex | (state == SENT) | (accept & ~((state == WAIT) & cancel));

  assign rs_to_ms_valid = rs_valid & ready_go & ~flush;
  assign out_go         = rs_to_ms_valid & ms_allowin;
  assign rs_allowin     = (state != WAIT) & (~rs_valid | (ready_go & ms_allowin));
  assign rs_discard     = accept & (state == WAIT) & (cancel | flush);

  assign data_wr    = mem_we;
  assign data_addr  = addr;
  assign data_size  = word_op ? 2'd2 : (half_op ? 2'd1 : 2'd0);
  assign data_wdata = st_b ? {4{rkd[7:0]}} : (st_h ? {2{rkd[15:0]}} : rkd);

  always_comb begin
    data_wstrb = 4'h0;
    if (st_w)      data_wstrb = 4'hF;
    else if (st_h) data_wstrb = 4'b0011 << addr[1:0];
    else if (st_b) data_wstrb = 4'b0001 << addr[1:0];
  end

  assign rs_to_ms_bus = {pc, result, dest, gr_we, ld_hu, ld_bu, ld_h, ld_b, ld_w,
                         is_ld, rs_ex, rs_ecode};
  assign rs_to_ds_bus = {rs_valid & is_ld, rs_valid, gr_we, dest, result};

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_valid <= 1'b0;
      bus_r    <= '0;
      state    <= IDLE;
      cancel   <= 1'b0;
    end else begin
      // rs_allowin is held low in WAIT, so a departure from WAIT must clear rs_valid here.
      if (rs_allowin) begin
        rs_valid <= es_to_rs_valid & ~flush;
        if (es_to_rs_valid) bus_r <= es_to_rs_bus;
      end else if (flush | out_go) begin
        rs_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept)        state <= out_go ? IDLE : SENT;
          else if (data_req) state <= WAIT;
        end
        WAIT: begin
          if (data_addr_ok) begin
            cancel <= 1'b0;
            state  <= (cancel | flush | out_go) ? IDLE : SENT;
          end else if (flush) begin
            cancel <= 1'b1;
          end
        end
        SENT: if (flush | out_go) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_stage.sv
// tb/tb_mem_req_stage.sv - randomized self-checking bench for mem_req_stage against a transaction model
module tb_mem_req_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         es_to_rs_valid;
  logic [237:0] es_to_rs_bus;
  logic         rs_allowin;
  logic         ms_allowin;
  logic         rs_to_ms_valid;
  logic [82:0]  rs_to_ms_bus;
  logic         flush;
  logic         data_req, data_wr;
  logic [1:0]   data_size;
  logic [3:0]   data_wstrb;
  logic [31:0]  data_addr, data_wdata;
  logic         data_addr_ok;
  logic         rs_discard;
  logic [39:0]  rs_to_ds_bus;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_req_stage dut (
    .clk(clk), .reset(reset),
    .es_to_rs_valid(es_to_rs_valid), .es_to_rs_bus(es_to_rs_bus), .rs_allowin(rs_allowin),
    .ms_allowin(ms_allowin), .rs_to_ms_valid(rs_to_ms_valid), .rs_to_ms_bus(rs_to_ms_bus),
    .flush(flush), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .rs_discard(rs_discard), .rs_to_ds_bus(rs_to_ds_bus)
  );

`ifdef RS_ALE_CHECK_EN
  localparam bit ALE_EN = 1'b1;
`else
  localparam bit ALE_EN = 1'b0;
`endif

  localparam int K_ALU = 0, K_LD_W = 1, K_LD_B = 2, K_LD_H = 3, K_LD_BU = 4, K_LD_HU = 5,
                 K_ST_W = 6, K_ST_H = 7, K_ST_B = 8;

  typedef struct {
    logic [31:0] pc, addr, rkd;
    logic [4:0]  dest;
    logic        gr_we, ex;
    logic [5:0]  ecode;
    int          kind;
  } instr_t;

  // ---------------- reference model ----------------
  function automatic int nbytes(int kind);
    case (kind)
      K_LD_W, K_ST_W:          return 4;
      K_LD_H, K_LD_HU, K_ST_H: return 2;
      K_LD_B, K_LD_BU, K_ST_B: return 1;
      default:                 return 0;
    endcase
  endfunction

  function automatic bit is_load(int kind);  return kind >= K_LD_W && kind <= K_LD_HU; endfunction
  function automatic bit is_store(int kind); return kind >= K_ST_W; endfunction

  function automatic bit m_ale(instr_t i);
    int n = nbytes(i.kind);
    int off = int'(i.addr[1:0]);
    return ALE_EN && !i.ex && n > 0 && (off % n) != 0;
  endfunction

  function automatic bit m_req(instr_t i);
    return nbytes(i.kind) > 0 && !i.ex && !m_ale(i);
  endfunction

  function automatic logic [31:0] m_addr(instr_t i);
    int n = nbytes(i.kind);
    int off = int'(i.addr[1:0]);
    logic [31:0] a = i.addr;
    if (!ALE_EN && n > 0) a = a - 32'(off % n);
    return a;
  endfunction

  function automatic logic [1:0] m_size(instr_t i);
    int n = nbytes(i.kind);
    return (n == 4) ? 2'd2 : (n == 2) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [3:0] m_wstrb(instr_t i);
    logic [3:0] s = 4'h0;
    int lane = int'(m_addr(i) & 32'h3);
    int n = nbytes(i.kind);
    if (is_store(i.kind))
      for (int b = 0; b < 4; b++) if (b >= lane && b < lane + n) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(instr_t i);
    case (nbytes(i.kind))
      1:       return {24'h0, i.rkd[7:0]} * 32'h01010101;
      2:       return {16'h0, i.rkd[15:0]} * 32'h00010001;
      default: return i.rkd;
    endcase
  endfunction

  function automatic logic [82:0] m_ms_bus(instr_t i);
    logic ex = i.ex | m_ale(i);
    logic [5:0] ec = m_ale(i) ? 6'h09 : i.ecode;
    return {i.pc, i.addr, i.dest, i.gr_we, i.kind == K_LD_HU, i.kind == K_LD_BU,
            i.kind == K_LD_H, i.kind == K_LD_B, i.kind == K_LD_W, is_load(i.kind), ex, ec};
  endfunction

  function automatic logic [39:0] m_ds_bus(instr_t i);
    return {is_load(i.kind), 1'b1, i.gr_we, i.dest, i.addr};
  endfunction

  function automatic logic [237:0] rand_bus();
    logic [237:0] b;
    for (int j = 0; j < 238; j++) b[j] = 1'($urandom);
    return b;
  endfunction

  function automatic logic [237:0] build_bus(instr_t i);
    logic [237:0] b = rand_bus();
    b[31:0] = i.pc;  b[63:32] = i.addr;  b[68:64] = i.dest;  b[69] = i.gr_we;
    b[70] = (i.kind == K_LD_W);  b[71] = (i.kind == K_LD_B);  b[72] = (i.kind == K_LD_H);
    b[73] = (i.kind == K_LD_BU); b[74] = (i.kind == K_LD_HU);
    b[125] = i.ex;  b[131:126] = i.ecode;  b[197:166] = i.rkd;
    b[198] = (i.kind == K_ST_W); b[199] = (i.kind == K_ST_H); b[200] = (i.kind == K_ST_B);
    b[201] = is_store(i.kind);
    return b;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.pc = $urandom; i.addr = $urandom; i.rkd = $urandom;
    i.dest = 5'($urandom); i.gr_we = 1'($urandom);
    i.ex = ($urandom_range(0, 7) == 0); i.ecode = 6'($urandom);
    i.kind = $urandom_range(K_ALU, K_ST_B);
    return i;
  endfunction

  function automatic instr_t req_instr();
    instr_t i = rand_instr();
    i.kind = $urandom_range(K_LD_W, K_ST_B);
    i.ex = 1'b0;
    i.addr = i.addr & ~32'(nbytes(i.kind) - 1);
    return i;
  endfunction

  task automatic load_instr(input instr_t i, input logic fl);
    es_to_rs_valid = 1'b1; es_to_rs_bus = build_bus(i); flush = fl;
    data_addr_ok = 1'b0; ms_allowin = 1'b1;
    @(posedge clk); #1;
    es_to_rs_valid = 1'b0; es_to_rs_bus = rand_bus(); flush = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; es_to_rs_valid = 1'b0; es_to_rs_bus = '0; flush = 1'b0;
    ms_allowin = 1'b1; data_addr_ok = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    vectors++; if ({data_req, data_wr, data_size, data_wstrb, rs_to_ms_valid, rs_discard} !== 10'h0) begin
      miscompares++; $display("FAIL reset_ctrl got=%b exp=0", {data_req, data_wr, data_size, data_wstrb, rs_to_ms_valid, rs_discard}); end
    vectors++; if ({data_addr, data_wdata} !== 64'h0) begin
      miscompares++; $display("FAIL reset_data got=%h exp=0", {data_addr, data_wdata}); end
    vectors++; if (rs_to_ms_bus !== 83'h0 || rs_to_ds_bus !== 40'h0) begin
      miscompares++; $display("FAIL reset_buses got=%h/%h exp=0", rs_to_ms_bus, rs_to_ds_bus); end
    vectors++; if (rs_allowin !== 1'b1) begin
      miscompares++; $display("FAIL reset_allowin got=%b exp=1", rs_allowin); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One instruction: request accepted after d cycles, then ms stalls s cycles.
  task automatic test_instr(input instr_t i, input int d_in, input int s, input string tag);
    bit req = m_req(i);
    int d = req ? d_in : 0;
    int last = d + s;
    logic [82:0] e_ms = m_ms_bus(i);
    logic [39:0] e_ds = m_ds_bus(i);
    logic e;
    load_instr(i, 1'b0);
    for (int k = 0; k <= last; k++) begin
      data_addr_ok = (k < d) ? 1'b0 : (k == d) ? 1'b1 : 1'($urandom);
      ms_allowin   = (k == last) ? 1'b1 : (k < d) ? 1'($urandom) : 1'b0;
      @(negedge clk);
      e = req && k <= d;
      vectors++; if (data_req !== e) begin
        miscompares++; $display("FAIL %s req k=%0d got=%b exp=%b", tag, k, data_req, e); end
      e = (k >= d);
      vectors++; if (rs_to_ms_valid !== e) begin
        miscompares++; $display("FAIL %s ms_valid k=%0d got=%b exp=%b", tag, k, rs_to_ms_valid, e); end
      e = (k == last) && (s > 0 || d == 0);
      vectors++; if (rs_allowin !== e) begin
        miscompares++; $display("FAIL %s allowin k=%0d got=%b exp=%b", tag, k, rs_allowin, e); end
      vectors++; if (rs_discard !== 1'b0) begin
        miscompares++; $display("FAIL %s discard k=%0d got=%b exp=0", tag, k, rs_discard); end
      vectors++; if (rs_to_ds_bus !== e_ds) begin
        miscompares++; $display("FAIL %s ds_bus k=%0d got=%h exp=%h", tag, k, rs_to_ds_bus, e_ds); end
      if (k >= d) begin
        vectors++; if (rs_to_ms_bus !== e_ms) begin
          miscompares++; $display("FAIL %s ms_bus k=%0d got=%h exp=%h", tag, k, rs_to_ms_bus, e_ms); end
      end
      if (req && k <= d) begin
        vectors++; if ({data_wr, data_size, data_wstrb, data_addr} !== {is_store(i.kind), m_size(i), m_wstrb(i), m_addr(i)}) begin
          miscompares++; $display("FAIL %s req_fields k=%0d got=%b/%0d/%b/%h exp=%b/%0d/%b/%h", tag, k,
            data_wr, data_size, data_wstrb, data_addr, is_store(i.kind), m_size(i), m_wstrb(i), m_addr(i)); end
        if (is_store(i.kind)) begin
          vectors++; if (data_wdata !== m_wdata(i)) begin
            miscompares++; $display("FAIL %s wdata k=%0d got=%h exp=%h", tag, k, data_wdata, m_wdata(i)); end
        end
      end
      @(posedge clk); #1;
    end
    data_addr_ok = 1'($urandom); ms_allowin = 1'($urandom);
    @(negedge clk);
    vectors++; if ({data_req, rs_to_ms_valid, rs_allowin, rs_to_ds_bus[39:38]} !== 5'b00100) begin
      miscompares++; $display("FAIL %s idle_after got=%b exp=00100", tag, {data_req, rs_to_ms_valid, rs_allowin, rs_to_ds_bus[39:38]}); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    instr_t i;
    i = rand_instr(); i.kind = K_ST_B; i.ex = 0; i.addr = 32'h0001C003; i.rkd = 32'h000000AB;
    test_instr(i, 0, 0, "st_b_1c003");
    i = rand_instr(); i.kind = K_LD_W; i.ex = 0; i.addr = 32'h00001000;
    test_instr(i, 3, 0, "ld_w_wait3");
    i = rand_instr(); i.kind = K_LD_H; i.ex = 0; i.addr = 32'h00001001;
    test_instr(i, 1, 0, "ld_h_1001");
    i = rand_instr(); i.kind = K_LD_W; i.ex = 1; i.ecode = 6'h0B; i.addr = 32'h00002002;
    test_instr(i, 2, 0, "ex_passthru");
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++)
      test_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 2), "random");
  endtask

  task automatic test_back_to_back();
    instr_t a = rand_instr(), b = rand_instr();
    a.kind = K_ALU; b.kind = K_ALU;
    flush = 1'b0; ms_allowin = 1'b1; data_addr_ok = 1'b0;
    es_to_rs_valid = 1'b1; es_to_rs_bus = build_bus(a);
    @(posedge clk); #1;
    es_to_rs_bus = build_bus(b);
    @(negedge clk);
    vectors++; if (rs_to_ms_valid !== 1'b1 || rs_allowin !== 1'b1 || rs_to_ms_bus !== m_ms_bus(a)) begin
      miscompares++; $display("FAIL b2b_first got=%b/%b/%h exp=1/1/%h", rs_to_ms_valid, rs_allowin, rs_to_ms_bus, m_ms_bus(a)); end
    @(posedge clk); #1;
    es_to_rs_valid = 1'b0;
    @(negedge clk);
    vectors++; if (rs_to_ms_valid !== 1'b1 || rs_to_ms_bus !== m_ms_bus(b)) begin
      miscompares++; $display("FAIL b2b_second got=%b/%h exp=1/%h", rs_to_ms_valid, rs_to_ms_bus, m_ms_bus(b)); end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (rs_to_ms_valid !== 1'b0) begin
      miscompares++; $display("FAIL b2b_drain got=%b exp=0", rs_to_ms_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_wait();
    instr_t i = req_instr();
    instr_t alu = rand_instr();
    alu.kind = K_ALU; alu.ex = 0;
    load_instr(i, 1'b0);
    @(posedge clk); #1;                       // IDLE -> WAIT, no addr_ok
    flush = 1'b1;
    @(negedge clk);
    vectors++; if ({data_req, rs_to_ms_valid, rs_discard} !== 3'b100) begin
      miscompares++; $display("FAIL fw_flush got=%b exp=100", {data_req, rs_to_ms_valid, rs_discard}); end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    vectors++; if ({data_req, rs_to_ms_valid, rs_allowin, rs_discard} !== 4'b1000 ||
                   data_addr !== m_addr(i) || data_wstrb !== m_wstrb(i)) begin
      miscompares++; $display("FAIL fw_hold got=%b %h %b exp=1000 %h %b", {data_req, rs_to_ms_valid, rs_allowin, rs_discard},
        data_addr, data_wstrb, m_addr(i), m_wstrb(i)); end
    @(posedge clk); #1;
    data_addr_ok = 1'b1; es_to_rs_valid = 1'b1; es_to_rs_bus = build_bus(alu);
    @(negedge clk);
    vectors++; if ({data_req, rs_to_ms_valid, rs_allowin, rs_discard} !== 4'b1001 || data_addr !== m_addr(i)) begin
      miscompares++; $display("FAIL fw_accept got=%b %h exp=1001 %h", {data_req, rs_to_ms_valid, rs_allowin, rs_discard}, data_addr, m_addr(i)); end
    @(posedge clk); #1;
    data_addr_ok = 1'b0; es_to_rs_valid = 1'b0;
    @(negedge clk);
    vectors++; if ({data_req, rs_to_ms_valid, rs_allowin, rs_discard} !== 4'b0010) begin
      miscompares++; $display("FAIL fw_after got=%b exp=0010", {data_req, rs_to_ms_valid, rs_allowin, rs_discard}); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_accept();
    instr_t i = req_instr();
    load_instr(i, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1; data_addr_ok = 1'b1;
    @(negedge clk);
    vectors++; if ({data_req, rs_to_ms_valid, rs_discard} !== 3'b101) begin
      miscompares++; $display("FAIL fa_same got=%b exp=101", {data_req, rs_to_ms_valid, rs_discard}); end
    @(posedge clk); #1;
    flush = 1'b0; data_addr_ok = 1'b1;
    @(negedge clk);
    vectors++; if ({data_req, rs_to_ms_valid, rs_allowin, rs_discard} !== 4'b0010) begin
      miscompares++; $display("FAIL fa_after got=%b exp=0010", {data_req, rs_to_ms_valid, rs_allowin, rs_discard}); end
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
  endtask

  task automatic test_flush_sent();
    instr_t i = req_instr();
    load_instr(i, 1'b0);
    data_addr_ok = 1'b1; ms_allowin = 1'b0;
    @(negedge clk);
    vectors++; if ({data_req, rs_to_ms_valid, rs_allowin} !== 3'b110) begin
      miscompares++; $display("FAIL fs_stall got=%b exp=110", {data_req, rs_to_ms_valid, rs_allowin}); end
    @(posedge clk); #1;
    data_addr_ok = 1'b0; flush = 1'b1; ms_allowin = 1'b1;
    @(negedge clk);
    vectors++; if ({data_req, rs_to_ms_valid, rs_discard} !== 3'b000) begin
      miscompares++; $display("FAIL fs_flush got=%b exp=000", {data_req, rs_to_ms_valid, rs_discard}); end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    vectors++; if ({data_req, rs_to_ms_valid, rs_allowin} !== 3'b001) begin
      miscompares++; $display("FAIL fs_after got=%b exp=001", {data_req, rs_to_ms_valid, rs_allowin}); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_incoming();
    instr_t a = rand_instr();
    instr_t m = req_instr();
    a.kind = K_ALU;
    load_instr(a, 1'b1);
    @(negedge clk);
    vectors++; if (rs_to_ms_valid !== 1'b0 || rs_to_ds_bus[38] !== 1'b0) begin
      miscompares++; $display("FAIL fi_dropped got=%b/%b exp=0/0", rs_to_ms_valid, rs_to_ds_bus[38]); end
    @(posedge clk); #1;
    load_instr(m, 1'b0);
    flush = 1'b1; data_addr_ok = 1'b1;
    @(negedge clk);
    vectors++; if ({data_req, rs_to_ms_valid, rs_discard} !== 3'b000) begin
      miscompares++; $display("FAIL fi_idle_flush got=%b exp=000", {data_req, rs_to_ms_valid, rs_discard}); end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    vectors++; if ({data_req, rs_to_ms_valid, rs_allowin} !== 3'b001) begin
      miscompares++; $display("FAIL fi_after got=%b exp=001", {data_req, rs_to_ms_valid, rs_allowin}); end
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    instr_t i = req_instr();
    load_instr(i, 1'b0);
    @(posedge clk); #1;                       // now in WAIT
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; data_addr_ok = 1'b1;
    @(negedge clk);
    vectors++; if ({data_req, rs_to_ms_valid, rs_discard, rs_allowin, rs_to_ds_bus[38]} !== 5'b00010) begin
      miscompares++; $display("FAIL rst_wait got=%b exp=00010", {data_req, rs_to_ms_valid, rs_discard, rs_allowin, rs_to_ds_bus[38]}); end
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush_wait();
    test_flush_accept();
    test_flush_sent();
    test_flush_incoming();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
